uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Serial transmit stage that sits directly downstream of the team's synchronous show-ahead FIFO (fifo_sync) in the MCU UART.
- Pops one word whenever the FIFO is non-empty and transmission is enabled.
- Serializes the word onto txd as a standard asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional parity, then 1 or 2 stop bits.
- Bit timing comes from an internal programmable clock divider.

Parameters:
- DATA_WIDTH, 8, width of one FIFO word and number of data bits per frame (5..9 supported).
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset
- tx_en  input  1  enable; new frames start only while high
- baud_div  input  DIV_WIDTH  bit period = baud_div+1 clk cycles; valid range is baud_div >= 1
- parity_en  input  1  1 = insert parity bit
- parity_odd  input  1  1 = odd parity, 0 = even parity
- stop2  input  1  1 = two stop bits, 0 = one stop bit
- fifo_empty  input  1  FIFO rd_empty
- fifo_data  input  DATA_WIDTH  FIFO q (show-ahead, valid while fifo_empty=0)
- fifo_rd_req  output  1  FIFO rd_req, one-cycle pop pulse
- txd  output  1  serial line, idles high
- busy  output  1  high from word capture until the end of the last stop bit
- frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
  - On reset: state=IDLE, txd=1, busy=0, fifo_rd_req=0, frame_done=0, all counters 0.
  - Reset asserted mid-frame aborts the frame immediately; txd returns to 1 asynchronously and the partially sent word is lost.
- All outputs are registered.
- State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1, busy=0.
  - If tx_en=1 and fifo_empty=0 at a clk edge, that edge does all of the following:
    - captures fifo_data into the shift register;
    - captures baud_div, parity_en, parity_odd and stop2 into frame-config registers;
    - computes parity = ^data XOR parity_odd;
    - sets fifo_rd_req=1 for exactly the following cycle;
    - sets busy=1 and txd=0, and moves to START.
  - The FIFO advances its pointer at the end of that cycle. Only one pop occurs per frame, so the one-cycle lag in FIFO empty status never causes a double pop.
- Bit timer:
  - Counter loads 0 on entry to each bit and increments each clk.
  - At count == captured baud_div the bit ends and the counter reloads 0.
  - Every bit, including start, parity and stop, lasts exactly baud_div+1 cycles.
- START: txd=0 for one bit period, then DATA.
- DATA:
  - txd = shift_reg[0]; the shift register shifts right at each bit end.
  - A bit index counts 0..DATA_WIDTH-1.
  - After the last data bit, go to PARITY if the captured parity_en=1, else STOP.
- PARITY: txd = captured parity bit for one bit period, then STOP.
- STOP:
  - txd=1 for 1 bit period, or 2 if the captured stop2=1.
  - At the end of the final stop bit: go to IDLE, busy=0, frame_done=1 for one cycle.
- Config changes: baud_div, parity_en, parity_odd and stop2 are sampled only at capture. Changes mid-frame affect the next frame only.
- tx_en deasserted mid-frame: the current frame completes normally, and no new capture happens afterwards.
- Back-to-back frames:
  - When the FIFO still has data, capture occurs on the first IDLE cycle.
  - Start-of-frame to start-of-frame spacing is therefore N_bits*(baud_div+1)+1 clks, where N_bits = 1+DATA_WIDTH+parity_en+(1+stop2).
- fifo_empty going high while a frame is in progress has no effect on that frame.
- baud_div=0 is outside the valid range; its behaviour is undefined.

Test Plan:
- Basic 8N1 frame: DATA_WIDTH=8, baud_div=3, parity_en=0, stop2=0, one word 0x55 in FIFO, tx_en=1.
  - fifo_rd_req is a single 1-cycle pulse.
  - txd bit sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 clks, 40 clks total.
  - frame_done pulses once; busy is high for 40 clks.
- Parity: word 0x55 with parity_en=1.
  - parity_odd=0 -> parity bit 0.
  - parity_odd=1 -> parity bit 1.
  - Word 0x07 with parity_odd=0 -> parity bit 1.
  - Frame length is 11 bits = 44 clks.
- Two stop bits and back-to-back: 0xA5 then 0x3C queued, stop2=1, baud_div=3.
  - Exactly two rd_req pulses.
  - Second start bit falls 45 clks after the first (11 bits*4+1).
  - The 0x3C data bits are 0,0,1,1,1,1,0,0.
- Enable and empty gating:
  - tx_en=0 with the FIFO non-empty -> no pop, txd stays 1.
  - tx_en dropped during data bit 3 -> the frame finishes and no further pop occurs.
  - FIFO empty with tx_en=1 -> remains IDLE.
- Config change mid-frame: change baud_div 3->7 during DATA.
  - The current frame keeps 4-clk bits.
  - The next frame uses 8-clk bits.
- Reset mid-frame: assert rstn=0 during DATA.
  - txd=1, busy=0, fifo_rd_req=0 immediately.
  - After release with the FIFO non-empty, a fresh full frame starts cleanly.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit serializer for the MCU UART. Pulls words from a show-ahead FIFO
// (fifo_sync) and sends each one as an asynchronous frame on txd:
// start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing comes from an internal divider: every bit lasts baud_div+1 clks.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   tx_en        new frames start only while high
//   baud_div     bit period minus one, in clk cycles (must be >= 1)
//   parity_en    1 = append a parity bit
//   parity_odd   1 = odd parity, 0 = even parity
//   stop2        1 = two stop bits, 0 = one
//   fifo_empty   FIFO rd_empty
//   fifo_data    FIFO show-ahead output word
//   fifo_rd_req  one-cycle pop pulse to the FIFO
//   txd          serial output, idles high
//   busy         high from word capture to the end of the last stop bit
//   frame_done   one-cycle pulse when a frame completes
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  tx_en,
   input  logic [DIV_WIDTH-1:0]  baud_div,
   input  logic                  parity_en,
   input  logic                  parity_odd,
   input  logic                  stop2,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_req,
   output logic                  txd,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   baud_cnt_q, baud_cnt_d;
   logic [DIV_WIDTH-1:0]   baud_div_q, baud_div_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
   logic                   stop_idx_q, stop_idx_d;
   logic                   par_en_q, par_en_d;
   logic                   par_bit_q, par_bit_d;
   logic                   stop2_q, stop2_d;
   logic                   txd_q, txd_d;
   logic                   busy_q, busy_d;
   logic                   rd_req_q, rd_req_d;
   logic                   done_q, done_d;
   logic                   bit_end;

   // The current bit ends on the cycle its counter reaches the captured divisor.
   assign bit_end = (baud_cnt_q == baud_div_q);

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      baud_div_d = baud_div_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      stop2_d    = stop2_q;
      rd_req_d   = 1'b0;
      done_d     = 1'b0;

      if (state_q != IDLE) begin
         baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            // Word and frame config are latched together so that later
            // changes on the config inputs only affect the next frame.
            if (tx_en && !fifo_empty) begin
               shift_d    = fifo_data;
               baud_div_d = baud_div;
               par_en_d   = parity_en;
               par_bit_d  = (^fifo_data) ^ parity_odd;
               stop2_d    = stop2;
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               rd_req_d   = 1'b1;
               state_d    = START;
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == LAST_IDX) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is decoded from the next state so txd is a plain register.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         PARITY:  txd_d = par_bit_d;
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         baud_div_q <= '0;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop2_q    <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         rd_req_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         baud_div_q <= baud_div_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         stop2_q    <= stop2_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         rd_req_q   <= rd_req_d;
         done_q     <= done_d;
      end
   end

   assign fifo_rd_req = rd_req_q;
   assign txd         = txd_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Bench for uart_tx_serializer. A small show-ahead FIFO model feeds the DUT;
// expected txd/busy/frame_done waveforms are built from a list of frames
// (bit list per frame, each bit held baud_div+1 cycles, one idle cycle with
// frame_done after each frame) and compared against cycles sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

   localparam int DW   = 8;
   localparam int DVW  = 16;
   localparam int MAXC = 512;

   logic           clk = 1'b0;
   logic           rstn = 1'b1;
   logic           tx_en = 1'b0;
   logic [DVW-1:0] baud_div = 16'd3;
   logic           parity_en = 1'b0;
   logic           parity_odd = 1'b0;
   logic           stop2 = 1'b0;
   logic           fifo_empty = 1'b1;
   logic [DW-1:0]  fifo_data = '0;
   logic           fifo_rd_req;
   logic           txd;
   logic           busy;
   logic           frame_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.DATA_WIDTH(DW), .DIV_WIDTH(DVW)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .tx_en       (tx_en),
      .baud_div    (baud_div),
      .parity_en   (parity_en),
      .parity_odd  (parity_odd),
      .stop2       (stop2),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .fifo_rd_req (fifo_rd_req),
      .txd         (txd),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   // ---------------- FIFO model (show-ahead) ----------------
   logic [DW-1:0] mem [64];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int rd_double = 0;
   logic rd_prev = 1'b0;

   always @(negedge clk) begin
      if (fifo_rd_req) begin
         if (rd_prev) rd_double++;
         rd_ptr++;
      end
      rd_prev    = fifo_rd_req;
      fifo_empty = (rd_ptr >= wr_ptr);
      fifo_data  = mem[rd_ptr % 64];
   end

   task automatic push(input logic [DW-1:0] d);
      mem[wr_ptr % 64] = d;
      wr_ptr++;
   endtask

   // ---------------- Reference model ----------------
   typedef struct {
      logic [DW-1:0] d;
      int            bd;
      logic          pe;
      logic          po;
      logic          s2;
   } frame_t;

   frame_t fr[$];
   logic [MAXC-1:0] exp_txd, exp_busy, exp_done;
   int exp_len;
   logic [MAXC-1:0] got_txd, got_busy, got_done;
   int p0;

   task automatic add_frame(input logic [DW-1:0] d, input int bd, input logic pe,
                            input logic po, input logic s2);
      frame_t f;
      f.d = d; f.bd = bd; f.pe = pe; f.po = po; f.s2 = s2;
      fr.push_back(f);
   endtask

   function automatic void model(input int tail);
      int t;
      logic bits[$];
      t = 0;
      exp_txd = '0; exp_busy = '0; exp_done = '0;
      foreach (fr[k]) begin
         bits.delete();
         bits.push_back(1'b0);
         for (int i = 0; i < DW; i++) bits.push_back(fr[k].d[i]);
         if (fr[k].pe) bits.push_back((^fr[k].d) ^ fr[k].po);
         bits.push_back(1'b1);
         if (fr[k].s2) bits.push_back(1'b1);
         foreach (bits[b]) begin
            for (int c = 0; c <= fr[k].bd; c++) begin
               exp_txd[t] = bits[b];
               exp_busy[t] = 1'b1;
               t++;
            end
         end
         exp_txd[t] = 1'b1;
         exp_done[t] = 1'b1;
         t++;
      end
      for (int i = 0; i < tail; i++) begin
         exp_txd[t] = 1'b1;
         t++;
      end
      exp_len = t;
   endfunction

   // Sample n cycles on the falling edge; optionally poke an input at one cycle.
   task automatic capture(input int n, input int act_at, input int act_kind, input int act_val);
      got_txd = '0; got_busy = '0; got_done = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         got_txd[i]  = txd;
         got_busy[i] = busy;
         got_done[i] = frame_done;
         if (i == act_at) begin
            if (act_kind == 1) tx_en = 1'b0;
            if (act_kind == 2) baud_div = DVW'(act_val);
         end
      end
   endtask

   task automatic go(input logic en, input int tail, input int act_at, input int act_kind,
                     input int act_val);
      model(tail);
      p0 = rd_ptr;
      @(negedge clk);
      @(negedge clk);
      tx_en = en;
      capture(exp_len, act_at, act_kind, act_val);
      tx_en = 1'b0;
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset;
      #2 rstn = 1'b0;
      #1;
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (fifo_rd_req !== 1'b0) begin errors++; $display("FAIL reset_rdreq got=%b exp=0", fifo_rd_req); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", frame_done); end
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      $display("reset: outputs checked during reset");
   endtask

   task automatic test_basic_8n1;
      baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
      fr.delete();
      push(8'h55);
      add_frame(8'h55, 3, 1'b0, 1'b0, 1'b0);
      go(1'b1, 4, -1, 0, 0);
      checks++; if (got_txd !== exp_txd) begin errors++; $display("FAIL basic_txd got=%h exp=%h", got_txd, exp_txd); end
      checks++; if (got_busy !== exp_busy) begin errors++; $display("FAIL basic_busy got=%h exp=%h", got_busy, exp_busy); end
      checks++; if (got_done !== exp_done) begin errors++; $display("FAIL basic_done got=%h exp=%h", got_done, exp_done); end
      checks++; if (rd_ptr - p0 !== 1) begin errors++; $display("FAIL basic_pops got=%0d exp=1", rd_ptr - p0); end
      checks++; if (rd_double !== 0) begin errors++; $display("FAIL basic_rdpulse got=%0d long pulses exp=0", rd_double); end
      $display("basic_8n1: word 0x55 bd=3, %0d cycles", exp_len);
   endtask

   task automatic test_parity;
      logic [DW-1:0] pd [3];
      logic          pod [3];
      pd  = '{8'h55, 8'h55, 8'h07};
      pod = '{1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         baud_div = 16'd3; parity_en = 1'b1; parity_odd = pod[k]; stop2 = 1'b0;
         fr.delete();
         push(pd[k]);
         add_frame(pd[k], 3, 1'b1, pod[k], 1'b0);
         go(1'b1, 4, -1, 0, 0);
         checks++; if (got_txd !== exp_txd) begin errors++; $display("FAIL parity%0d_txd got=%h exp=%h", k, got_txd, exp_txd); end
         checks++; if (got_busy !== exp_busy) begin errors++; $display("FAIL parity%0d_busy got=%h exp=%h", k, got_busy, exp_busy); end
         checks++; if (got_done !== exp_done) begin errors++; $display("FAIL parity%0d_done got=%h exp=%h", k, got_done, exp_done); end
         $display("parity: word 0x%h odd=%0d", pd[k], pod[k]);
      end
      parity_en = 1'b0;
   endtask

   task automatic test_back_to_back;
      int second;
      baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b1;
      fr.delete();
      push(8'hA5); push(8'h3C);
      add_frame(8'hA5, 3, 1'b0, 1'b0, 1'b1);
      add_frame(8'h3C, 3, 1'b0, 1'b0, 1'b1);
      go(1'b1, 4, -1, 0, 0);
      second = -1;
      for (int i = 1; i < exp_len; i++)
         if (second < 0 && got_busy[i-1] === 1'b0 && got_busy[i] === 1'b1) second = i;
      checks++; if (got_txd !== exp_txd) begin errors++; $display("FAIL b2b_txd got=%h exp=%h", got_txd, exp_txd); end
      checks++; if (got_busy !== exp_busy) begin errors++; $display("FAIL b2b_busy got=%h exp=%h", got_busy, exp_busy); end
      checks++; if (got_done !== exp_done) begin errors++; $display("FAIL b2b_done got=%h exp=%h", got_done, exp_done); end
      checks++; if (rd_ptr - p0 !== 2) begin errors++; $display("FAIL b2b_pops got=%0d exp=2", rd_ptr - p0); end
      checks++; if (second !== 11 * 4 + 1) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", second, 11 * 4 + 1); end
      stop2 = 1'b0;
      $display("back_to_back: 0xA5,0x3C stop2 second start at %0d", second);
   endtask

   task automatic test_gating;
      baud_div = 16'd3; parity_en = 1'b0; stop2 = 1'b0;
      // FIFO empty, enabled: stays idle.
      fr.delete();
      go(1'b1, 20, -1, 0, 0);
      checks++; if (got_txd !== exp_txd || got_busy !== exp_busy) begin errors++; $display("FAIL empty_idle txd=%h busy=%h exp txd=%h", got_txd, got_busy, exp_txd); end
      checks++; if (rd_ptr - p0 !== 0) begin errors++; $display("FAIL empty_pops got=%0d exp=0", rd_ptr - p0); end
      // FIFO non-empty, disabled: no pop.
      push(8'h96);
      go(1'b0, 20, -1, 0, 0);
      checks++; if (got_txd !== exp_txd || got_busy !== exp_busy) begin errors++; $display("FAIL disabled_idle txd=%h busy=%h exp txd=%h", got_txd, got_busy, exp_txd); end
      checks++; if (rd_ptr - p0 !== 0) begin errors++; $display("FAIL disabled_pops got=%0d exp=0", rd_ptr - p0); end
      // Drop tx_en during data bit 3: frame completes, 0x3B stays queued.
      push(8'h3B);
      add_frame(8'h96, 3, 1'b0, 1'b0, 1'b0);
      go(1'b1, 20, 17, 1, 0);
      checks++; if (got_txd !== exp_txd) begin errors++; $display("FAIL endrop_txd got=%h exp=%h", got_txd, exp_txd); end
      checks++; if (got_busy !== exp_busy) begin errors++; $display("FAIL endrop_busy got=%h exp=%h", got_busy, exp_busy); end
      checks++; if (got_done !== exp_done) begin errors++; $display("FAIL endrop_done got=%h exp=%h", got_done, exp_done); end
      checks++; if (rd_ptr - p0 !== 1) begin errors++; $display("FAIL endrop_pops got=%0d exp=1", rd_ptr - p0); end
      $display("gating: empty, disabled and mid-frame disable scenarios");
   endtask

   task automatic test_config_change;
      baud_div = 16'd3; parity_en = 1'b0; stop2 = 1'b0;
      fr.delete();
      push(8'hE1);
      add_frame(8'h3B, 3, 1'b0, 1'b0, 1'b0);
      add_frame(8'hE1, 7, 1'b0, 1'b0, 1'b0);
      go(1'b1, 4, 10, 2, 7);
      checks++; if (got_txd !== exp_txd) begin errors++; $display("FAIL cfg_txd got=%h exp=%h", got_txd, exp_txd); end
      checks++; if (got_busy !== exp_busy) begin errors++; $display("FAIL cfg_busy got=%h exp=%h", got_busy, exp_busy); end
      checks++; if (got_done !== exp_done) begin errors++; $display("FAIL cfg_done got=%h exp=%h", got_done, exp_done); end
      checks++; if (rd_ptr - p0 !== 2) begin errors++; $display("FAIL cfg_pops got=%0d exp=2", rd_ptr - p0); end
      $display("config_change: baud_div 3->7 mid-frame");
   endtask

   task automatic test_reset_mid_frame;
      baud_div = 16'd3; parity_en = 1'b0; stop2 = 1'b0;
      push(8'h00);
      @(negedge clk);
      @(negedge clk);
      tx_en = 1'b1;
      capture(10, -1, 0, 0);
      checks++; if (txd !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre txd=%b busy=%b exp txd=0 busy=1", txd, busy); end
      rstn = 1'b0;
      #1;
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd got=%b exp=1", txd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (fifo_rd_req !== 1'b0) begin errors++; $display("FAIL rstmid_rdreq got=%b exp=0", fifo_rd_req); end
      tx_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      fr.delete();
      push(8'h5A);
      add_frame(8'h5A, 3, 1'b0, 1'b0, 1'b0);
      go(1'b1, 4, -1, 0, 0);
      checks++; if (got_txd !== exp_txd) begin errors++; $display("FAIL rstmid_after_txd got=%h exp=%h", got_txd, exp_txd); end
      checks++; if (got_busy !== exp_busy) begin errors++; $display("FAIL rstmid_after_busy got=%h exp=%h", got_busy, exp_busy); end
      checks++; if (got_done !== exp_done) begin errors++; $display("FAIL rstmid_after_done got=%h exp=%h", got_done, exp_done); end
      checks++; if (rd_ptr - p0 !== 1) begin errors++; $display("FAIL rstmid_after_pops got=%0d exp=1", rd_ptr - p0); end
      $display("reset_mid_frame: abort then fresh frame 0x5A");
   endtask

   task automatic test_random;
      int n, bd;
      logic pe, po, s2;
      logic [DW-1:0] d;
      for (int it = 0; it < 6; it++) begin
         n  = $urandom_range(1, 3);
         bd = $urandom_range(1, 4);
         pe = 1'($urandom_range(0, 1));
         po = 1'($urandom_range(0, 1));
         s2 = 1'($urandom_range(0, 1));
         baud_div = DVW'(bd); parity_en = pe; parity_odd = po; stop2 = s2;
         fr.delete();
         for (int k = 0; k < n; k++) begin
            d = DW'($urandom);
            push(d);
            add_frame(d, bd, pe, po, s2);
         end
         go(1'b1, 4, -1, 0, 0);
         checks++; if (got_txd !== exp_txd) begin errors++; $display("FAIL rand%0d_txd got=%h exp=%h", it, got_txd, exp_txd); end
         checks++; if (got_busy !== exp_busy) begin errors++; $display("FAIL rand%0d_busy got=%h exp=%h", it, got_busy, exp_busy); end
         checks++; if (got_done !== exp_done) begin errors++; $display("FAIL rand%0d_done got=%h exp=%h", it, got_done, exp_done); end
         checks++; if (rd_ptr - p0 !== n) begin errors++; $display("FAIL rand%0d_pops got=%0d exp=%0d", it, rd_ptr - p0, n); end
         $display("random %0d: %0d words bd=%0d pe=%0d po=%0d s2=%0d", it, n, bd, pe, po, s2);
      end
   endtask

   initial begin
      test_reset;
      test_basic_8n1;
      test_parity;
      test_back_to_back;
      test_gating;
      test_config_change;
      test_reset_mid_frame;
      test_random;
      checks++; if (rd_double !== 0) begin errors++; $display("FAIL rdreq_width got=%0d long pulses exp=0", rd_double); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
